// File: rtl/address_register_file_param_if.sv
// Bus bundle for the address register file: function/select inputs in,
// read ports, flags and the raw register view out.
interface address_register_file_param_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 3,
    parameter int SEL_W    = 2
);
    logic [WIDTH-1:0]          i;
    logic [1:0]                fun_sel;
    logic [NUM_REGS-1:0]       reg_sel;
    logic [SEL_W-1:0]          outc_sel;
    logic [SEL_W-1:0]          outd_sel;
    logic                      flag_clr;
    logic [WIDTH-1:0]          outc;
    logic [WIDTH-1:0]          outd;
    logic                      sp_overflow;
    logic                      sp_underflow;
    logic [NUM_REGS*WIDTH-1:0] regq;

    // Datapath side drives the controls and observes the file.
    modport master (
        output i, fun_sel, reg_sel, outc_sel, outd_sel, flag_clr,
        input  outc, outd, sp_overflow, sp_underflow, regq
    );

    // Register file side.
    modport slave (
        input  i, fun_sel, reg_sel, outc_sel, outd_sel, flag_clr,
        output outc, outd, sp_overflow, sp_underflow, regq
    );
endinterface

// File: rtl/address_register_file_param.sv
// Parametrised address register file: register 0 is the PC, register
// SP_INDEX the stack pointer, the rest general address registers. A shared
// function bus updates every selected register; two combinational read
// ports; sticky stack overflow/underflow flags against configurable bounds.
module address_register_file_param #(
    parameter int               WIDTH    = 16,
    parameter int               NUM_REGS = 3,
    parameter int               SP_INDEX = 1,
    parameter int               SEL_W    = 2,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter logic [WIDTH-1:0] SP_RESET = '1,   // empty-stack top
    parameter logic [WIDTH-1:0] SP_LOW   = '0,   // full-stack bottom
    parameter bit               SATURATE = 1'b0
) (
    input logic                           clk,
    input logic                           rst,
    address_register_file_param_if.slave  bus
);

    typedef enum logic [1:0] {
        FUN_DEC  = 2'b00,
        FUN_INC  = 2'b01,
        FUN_LOAD = 2'b10,
        FUN_CLR  = 2'b11
    } fun_e;

    fun_e             fun;
    logic [WIDTH-1:0] regs      [NUM_REGS];
    logic [WIDTH-1:0] regs_next [NUM_REGS];
    logic             push_fault;
    logic             pop_fault;
    logic             ovf_q;
    logic             unf_q;
    logic [WIDTH-1:0] outc_val;
    logic [WIDTH-1:0] outd_val;

    assign fun = fun_e'(bus.fun_sel);

    // Result of one function applied to one register value.
    function automatic logic [WIDTH-1:0] apply_fun(
        input fun_e             f,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] d
    );
        case (f)
            FUN_DEC:  return (SATURATE && v == '0) ? v : v - WIDTH'(1);
            FUN_INC:  return (SATURATE && v == '1) ? v : v + WIDTH'(1);
            FUN_LOAD: return d;
            default:  return '0;
        endcase
    endfunction

    // Reset value for each register role.
    function automatic logic [WIDTH-1:0] reset_value(input int k);
        if (k == 0)        return PC_RESET;
        if (k == SP_INDEX) return SP_RESET;
        return '0;
    endfunction

    // Next state: selected registers take the function, others hold.
    // NOTE: both branches of the select assign every entry, so no latch can form.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_next[k] = bus.reg_sel[k] ? apply_fun(fun, regs[k], bus.i) : regs[k];
        end
    end

    // Stack bound violations are judged on the pre-edge SP; load/clear never count.
    assign push_fault = bus.reg_sel[SP_INDEX] && (fun == FUN_DEC) && (regs[SP_INDEX] <= SP_LOW);
    assign pop_fault  = bus.reg_sel[SP_INDEX] && (fun == FUN_INC) && (regs[SP_INDEX] >= SP_RESET);

    // Register bank update with asynchronous reset to per-role vectors.
    // NOTE: this array is a bank of flops, not a RAM, so every entry is reset to its role's vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= reset_value(k);
        end else begin
            // NOTE: non-blocking so every register samples only pre-edge values.
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= regs_next[k];
        end
    end

    // Sticky flags: a new violation beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push_fault)        ovf_q <= 1'b1;
            else if (bus.flag_clr) ovf_q <= 1'b0;
            if (pop_fault)         unf_q <= 1'b1;
            else if (bus.flag_clr) unf_q <= 1'b0;
        end
    end

    // Read ports: out-of-range selects fall back to the last register.
    always_comb begin
        outc_val = regs[NUM_REGS-1];
        outd_val = regs[NUM_REGS-1];
        for (int k = 0; k < NUM_REGS - 1; k++) begin
            if (int'(bus.outc_sel) == k) outc_val = regs[k];
            if (int'(bus.outd_sel) == k) outd_val = regs[k];
        end
    end

    assign bus.outc         = outc_val;
    assign bus.outd         = outd_val;
    assign bus.sp_overflow  = ovf_q;
    assign bus.sp_underflow = unf_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regq
        assign bus.regq[k*WIDTH +: WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_address_register_file_param.sv
// Self-checking bench: a wrap-around and a saturating instance receive the
// same stimulus and are compared against an integer reference model.
module tb_address_register_file_param;

    localparam int          NREG = 3;
    localparam int unsigned MAXV = 65535;

    logic clk;
    logic rst;

    address_register_file_param_if #(.WIDTH(16), .NUM_REGS(NREG), .SEL_W(2)) bus_w ();
    address_register_file_param_if #(.WIDTH(16), .NUM_REGS(NREG), .SEL_W(2)) bus_s ();

    address_register_file_param #(.SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(bus_w.slave));
    address_register_file_param #(.SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Currently driven inputs (shared by both instances).
    logic [15:0] cur_i;
    logic [1:0]  cur_fun;
    logic [2:0]  cur_rs;
    logic [1:0]  cur_oc;
    logic [1:0]  cur_od;
    logic        cur_fc;

    // Reference model: index 0 = wrap instance, 1 = saturating instance.
    int unsigned m_reg [2][NREG];
    bit          m_ovf [2];
    bit          m_unf [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] iv, input logic [1:0] f, input logic [2:0] rs,
                         input logic [1:0] oc, input logic [1:0] od, input logic fc);
        cur_i = iv; cur_fun = f; cur_rs = rs; cur_oc = oc; cur_od = od; cur_fc = fc;
        bus_w.i = iv; bus_w.fun_sel = f; bus_w.reg_sel = rs;
        bus_w.outc_sel = oc; bus_w.outd_sel = od; bus_w.flag_clr = fc;
        bus_s.i = iv; bus_s.fun_sel = f; bus_s.reg_sel = rs;
        bus_s.outc_sel = oc; bus_s.outd_sel = od; bus_s.flag_clr = fc;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_reg[d][0] = 0;
            m_reg[d][1] = MAXV;
            m_reg[d][2] = 0;
            m_ovf[d] = 1'b0;
            m_unf[d] = 1'b0;
        end
    endtask

    // One clock edge of the architectural rules, using the driven inputs.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int unsigned sp = m_reg[d][1];
            bit sp_sel = cur_rs[1];
            bit set_o  = sp_sel && cur_fun == 2'b00 && sp <= 0;
            bit set_u  = sp_sel && cur_fun == 2'b01 && sp >= MAXV;
            for (int k = 0; k < NREG; k++) begin
                if (cur_rs[k]) begin
                    case (cur_fun)
                        2'b00: if (m_reg[d][k] == 0) m_reg[d][k] = (d == 1) ? 0 : MAXV;
                               else m_reg[d][k] = m_reg[d][k] - 1;
                        2'b01: if (m_reg[d][k] == MAXV) m_reg[d][k] = (d == 1) ? MAXV : 0;
                               else m_reg[d][k] = m_reg[d][k] + 1;
                        2'b10: m_reg[d][k] = cur_i;
                        default: m_reg[d][k] = 0;
                    endcase
                end
            end
            if (set_o) m_ovf[d] = 1'b1; else if (cur_fc) m_ovf[d] = 1'b0;
            if (set_u) m_unf[d] = 1'b1; else if (cur_fc) m_unf[d] = 1'b0;
        end
    endtask

    task automatic check_dut(input string tag, input int d, input logic [47:0] regq,
                             input logic [15:0] oc, input logic [15:0] od,
                             input logic ovf, input logic unf);
        logic [63:0] e_regq;
        int ci;
        int di;
        e_regq = '0;
        for (int k = 0; k < NREG; k++) e_regq[k*16 +: 16] = 16'(m_reg[d][k]);
        ci = (int'(cur_oc) >= NREG) ? NREG - 1 : int'(cur_oc);
        di = (int'(cur_od) >= NREG) ? NREG - 1 : int'(cur_od);
        check({tag, "_regq"}, 64'(regq), e_regq);
        check({tag, "_outc"}, 64'(oc), 64'(m_reg[d][ci]));
        check({tag, "_outd"}, 64'(od), 64'(m_reg[d][di]));
        check({tag, "_ovf"},  64'(ovf), 64'(m_ovf[d]));
        check({tag, "_unf"},  64'(unf), 64'(m_unf[d]));
    endtask

    task automatic check_all(input string tag);
        check_dut({tag, "_wrap"}, 0, bus_w.regq, bus_w.outc, bus_w.outd,
                  bus_w.sp_overflow, bus_w.sp_underflow);
        check_dut({tag, "_sat"}, 1, bus_s.regq, bus_s.outc, bus_s.outd,
                  bus_s.sp_overflow, bus_s.sp_underflow);
    endtask

    // Called at a falling edge right after drive(): check pre-edge, clock, check.
    task automatic step(input string tag);
        #1 check_all({tag, "_pre"});
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] iv;
        logic [1:0]  f;
        logic [2:0]  rs;

        rst = 1'b1;
        drive(16'h0000, 2'b00, 3'b000, 2'd1, 2'd3, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst_active");

        // Reset release: PC=0, SP=FFFF (OutC sel 1), AR=0 (OutD sel 3).
        rst = 1'b0;
        #1 check_all("reset");
        @(negedge clk);

        // Load PC; OutC reads old value before the edge.
        drive(16'h1234, 2'b10, 3'b001, 2'd0, 2'd3, 1'b0);
        step("load_pc");

        // Pop at SP=FFFF: wrap -> 0000, saturate -> FFFF, underflow set in both.
        drive(16'h0000, 2'b01, 3'b010, 2'd1, 2'd0, 1'b0);
        step("underflow");

        // Load SP=0000 (no flag change), then push past the bottom.
        drive(16'h0000, 2'b10, 3'b010, 2'd1, 2'd2, 1'b0);
        step("load_sp0");
        drive(16'h0000, 2'b00, 3'b010, 2'd1, 2'd2, 1'b0);
        step("overflow");

        // FlagClr with nothing selected clears both flags.
        drive(16'h0000, 2'b00, 3'b000, 2'd1, 2'd2, 1'b1);
        step("flag_clr");

        // Set beats clear in the same cycle.
        drive(16'h0000, 2'b10, 3'b010, 2'd1, 2'd2, 1'b0);
        step("reload_sp0");
        drive(16'h0000, 2'b00, 3'b010, 2'd1, 2'd0, 1'b1);
        step("set_wins");
        drive(16'h0000, 2'b00, 3'b000, 2'd1, 2'd0, 1'b1);
        step("flag_clr2");

        // Multi-select increment then clear.
        drive(16'h0005, 2'b10, 3'b001, 2'd0, 2'd1, 1'b0);
        step("ld_pc5");
        drive(16'h0010, 2'b10, 3'b010, 2'd0, 2'd1, 1'b0);
        step("ld_sp10");
        drive(16'h00FF, 2'b10, 3'b100, 2'd2, 2'd3, 1'b0);
        step("ld_ar");
        drive(16'h0000, 2'b01, 3'b111, 2'd2, 2'd1, 1'b0);
        step("multi_inc");
        drive(16'h0000, 2'b11, 3'b111, 2'd0, 2'd3, 1'b0);
        step("multi_clr");

        // Saturation edges on a general register.
        drive(16'h0000, 2'b00, 3'b100, 2'd3, 2'd2, 1'b0);
        step("ar_dec_zero");
        drive(16'hFFFF, 2'b10, 3'b100, 2'd3, 2'd0, 1'b0);
        step("ar_ld_max");
        drive(16'h0000, 2'b01, 3'b100, 2'd2, 2'd3, 1'b0);
        step("ar_inc_max");

        // Randomised traffic, biased toward stack bounds.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0:       iv = 16'h0000;
                1:       iv = 16'hFFFF;
                2:       iv = 16'(16'h0001 + $urandom_range(0, 1));
                default: iv = 16'($urandom);
            endcase
            f  = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                f  = 2'($urandom_range(0, 1));
                rs = rs | 3'b010;
            end
            drive(iv, f, rs, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0));
            step("rand");
        end

        // Asynchronous reset between edges while a load is pending.
        drive(16'hABCD, 2'b10, 3'b111, 2'd0, 2'd1, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0000, 2'b00, 3'b000, 2'd0, 2'd1, 1'b0);
        #1 check_all("post_rst");
        @(negedge clk);
        drive(16'h5A5A, 2'b10, 3'b111, 2'd3, 2'd0, 1'b0);
        step("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/address_register_file_param.md
Name: address_register_file_param

Overview:
Parametrised address register file for the datapath: NUM_REGS address registers of WIDTH bits, with a shared load/increment/decrement/clear function bus and two independent combinational read ports (OutC, OutD). Register 0 is the program counter and register SP_INDEX is the stack pointer. The block adds a reset vector per role, optional saturating arithmetic, and sticky stack overflow/underflow flags checked against configurable stack bounds. It replaces the fixed three-register 16-bit address file in the CPU datapath.

Parameters:
WIDTH, 16, bit width of every register and of I/OutC/OutD
NUM_REGS, 3, number of registers; minimum 3; index 0 = PC, SP_INDEX = SP, others = general address registers (AR...)
SP_INDEX, 1, index of the stack pointer; 1 <= SP_INDEX < NUM_REGS
SEL_W, 2, width of OutCSel/OutDSel; must satisfy 2**SEL_W >= NUM_REGS
PC_RESET, 0, PC value on reset
SP_RESET, 16'hFFFF, SP value on reset; also the stack upper bound (empty stack)
SP_LOW, 16'h0000, stack lower bound (full stack)
SATURATE, 0, 0 = wrap-around arithmetic; 1 = saturate at 0 / all-ones

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
I  input  WIDTH  load data
FunSel  input  2  00 decrement, 01 increment, 10 load I, 11 clear
RegSel  input  NUM_REGS  one-hot-or-multi enable; bit k enables register k (active high)
OutCSel  input  SEL_W  read select for OutC
OutDSel  input  SEL_W  read select for OutD
FlagClr  input  1  synchronous clear of both sticky flags
OutC  output  WIDTH  selected register value
OutD  output  WIDTH  selected register value
SPOverflow  output  1  sticky; push past SP_LOW attempted
SPUnderflow  output  1  sticky; pop past SP_RESET attempted
RegQ  output  NUM_REGS*WIDTH  all register values, register k at bits [k*WIDTH +: WIDTH], for the testbench

Behaviour:
- Reset (async, while high): PC=PC_RESET, SP=SP_RESET, all other registers = 0, SPOverflow=SPUnderflow=0. Clock edges are ignored while Reset is high.
- On each rising Clock edge, every register with its RegSel bit set applies FunSel. Registers with the bit clear hold. Multiple set bits update all selected registers with the same function in the same cycle.
- Arithmetic is modulo 2**WIDTH when SATURATE=0.
- With SATURATE=1: decrement at 0 holds 0, increment at all-ones holds all-ones. Load and clear are unaffected.
- Reads are combinational from the registered values, with no write bypass: a write becomes visible on OutC/OutD after the edge.
- A select value >= NUM_REGS returns register NUM_REGS-1.
- Stack convention: push = SP decrement, pop = SP increment.
- SPOverflow is set at the edge where SP is selected with FunSel=00 and SP <= SP_LOW (unsigned). The SP value still follows the wrap or saturate rule.
- SPUnderflow is set at the edge where SP is selected with FunSel=01 and SP >= SP_RESET (unsigned). The SP value still follows the wrap or saturate rule.
- Load and clear of SP never set flags, even when the result is out of bounds.
- Flags stay set until FlagClr is sampled high at an edge. If a set condition and FlagClr occur in the same cycle, the set wins and the flag remains 1.
- Reset asserted mid-operation overrides any pending update immediately and clears the flags.

Test Plan:
- Reset check: assert Reset, release it -> RegQ shows PC=0000, SP=FFFF, AR=0000; both flags 0; OutCSel=1 -> OutC=FFFF.
- Load and read: I=1234, RegSel=001, FunSel=10, one edge -> PC=1234; OutCSel=0, OutDSel=3 -> OutC=1234, OutD=AR=0000; before the edge OutC still reads 0000.
- Underflow: SP=FFFF, RegSel=010, FunSel=01 -> SATURATE=0: SP=0000, SPUnderflow=1; SATURATE=1: SP=FFFF, SPUnderflow=1.
- Overflow and flag rules: load SP=0000, then decrement -> SP=FFFF, SPOverflow=1. Pulse FlagClr with RegSel=0 -> flag clears. Repeat the decrement at SP=0000 with FlagClr=1 in the same cycle -> flag stays 1.
- Multi-select: RegSel=111, FunSel=01 from PC=0005, SP=0010, AR=00FF -> 0006, 0011, 0100; then FunSel=11 -> all 0000, no flags set.
- Async reset mid-update: assert Reset between edges while RegSel=111, FunSel=10, I=ABCD -> outputs go to reset values without waiting for the clock, and no load occurs on the next edge while Reset is high.
